// File: rtl/mem_ctrl_arbiter.sv
// Round-robin arbiter that shares one memory-controller command port between NUM_REQ
// requesters, keeps one transaction in flight, and re-issues commands the controller missed.
module mem_ctrl_arbiter #(
    parameter int NUM_REQ       = 2,
    parameter int ISSUE_TIMEOUT = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    IN_req,
    input  logic [NUM_REQ-1:0]    IN_writeBack,
    input  logic [NUM_REQ*32-1:0] IN_sramAddr,
    input  logic [NUM_REQ*32-1:0] IN_extAddr,
    input  logic [NUM_REQ*32-1:0] IN_extWBAddr,
    input  logic [NUM_REQ*16-1:0] IN_size,
    output logic [NUM_REQ-1:0]    OUT_ack,
    output logic [NUM_REQ-1:0]    OUT_done,
    output logic                  OUT_MC_startRead,
    output logic                  OUT_MC_writeBack,
    output logic [31:0]           OUT_MC_sramAddr,
    output logic [31:0]           OUT_MC_extAddr,
    output logic [31:0]           OUT_MC_extWBAddr,
    output logic [15:0]           OUT_MC_size,
    input  logic                  IN_MC_busy,
    output logic                  OUT_busy
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(ISSUE_TIMEOUT) + 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    typedef struct packed {
        logic        write_back;
        logic [31:0] sram_addr;
        logic [31:0] ext_addr;
        logic [31:0] ext_wb_addr;
        logic [15:0] size;
    } cmd_t;

    state_t             state, state_n;
    logic [PTR_W-1:0]   rr_ptr, rr_ptr_n;
    logic [PTR_W-1:0]   grant, grant_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [NUM_REQ-1:0] ack_n, done_n;
    logic               start_n;
    cmd_t               cmd_q, cmd_n;

    logic               pick_valid;
    logic [PTR_W-1:0]   pick;

    // First asserted request at or after rr_ptr, wrapping around.
    always_comb begin
        pick_valid = 1'b0;
        pick       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!pick_valid && IN_req[(int'(rr_ptr) + i) % NUM_REQ]) begin
                pick_valid = 1'b1;
                pick       = PTR_W'((int'(rr_ptr) + i) % NUM_REQ);
            end
        end
    end

    always_comb begin
        // NOTE: every signal gets a default before the case so no latch is inferred.
        state_n  = state;
        rr_ptr_n = rr_ptr;
        grant_n  = grant;
        cnt_n    = cnt;
        cmd_n    = cmd_q;
        ack_n    = '0;
        done_n   = '0;
        start_n  = 1'b0;

        case (state)
            IDLE: begin
                if (pick_valid && !IN_MC_busy) begin
                    ack_n[pick]       = 1'b1;
                    start_n           = 1'b1;
                    cmd_n.write_back  = IN_writeBack[pick];
                    cmd_n.sram_addr   = IN_sramAddr[32*int'(pick) +: 32];
                    cmd_n.ext_addr    = IN_extAddr[32*int'(pick) +: 32];
                    cmd_n.ext_wb_addr = IN_extWBAddr[32*int'(pick) +: 32];
                    cmd_n.size        = IN_size[16*int'(pick) +: 16];
                    grant_n           = pick;
                    rr_ptr_n          = PTR_W'((int'(pick) + 1) % NUM_REQ);
                    state_n           = ISSUE;
                end
            end
            ISSUE: begin
                state_n = WAIT_BUSY;
                cnt_n   = '0;
            end
            WAIT_BUSY: begin
                if (IN_MC_busy) begin
                    state_n = WAIT_DONE;
                end else if (cnt == CNT_W'(ISSUE_TIMEOUT - 1)) begin
                    // Controller never saw the strobe: pulse it again, same command, no new ack.
                    start_n = 1'b1;
                    state_n = ISSUE;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!IN_MC_busy) begin
                    done_n[grant] = 1'b1;
                    state_n       = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state            <= IDLE;
            rr_ptr           <= '0;
            grant            <= '0;
            cnt              <= '0;
            cmd_q            <= '0;
            OUT_ack          <= '0;
            OUT_done         <= '0;
            OUT_MC_startRead <= 1'b0;
            OUT_busy         <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop updates from the same pre-edge values.
            state            <= state_n;
            rr_ptr           <= rr_ptr_n;
            grant            <= grant_n;
            cnt              <= cnt_n;
            cmd_q            <= cmd_n;
            OUT_ack          <= ack_n;
            OUT_done         <= done_n;
            OUT_MC_startRead <= start_n;
            OUT_busy         <= (state_n != IDLE);
        end
    end

    assign OUT_MC_writeBack = cmd_q.write_back;
    assign OUT_MC_sramAddr  = cmd_q.sram_addr;
    assign OUT_MC_extAddr   = cmd_q.ext_addr;
    assign OUT_MC_extWBAddr = cmd_q.ext_wb_addr;
    assign OUT_MC_size      = cmd_q.size;

endmodule

// File: tb/tb_mem_ctrl_arbiter.sv
// Directed bench for mem_ctrl_arbiter: the bench plays both the requesters and the
// memory controller, cycle by cycle, and checks each output against hand-derived values.
module tb_mem_ctrl_arbiter;

    localparam int NUM_REQ       = 2;
    localparam int ISSUE_TIMEOUT = 8;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NUM_REQ-1:0]    IN_req;
    logic [NUM_REQ-1:0]    IN_writeBack;
    logic [NUM_REQ*32-1:0] IN_sramAddr;
    logic [NUM_REQ*32-1:0] IN_extAddr;
    logic [NUM_REQ*32-1:0] IN_extWBAddr;
    logic [NUM_REQ*16-1:0] IN_size;
    logic [NUM_REQ-1:0]    OUT_ack;
    logic [NUM_REQ-1:0]    OUT_done;
    logic                  OUT_MC_startRead;
    logic                  OUT_MC_writeBack;
    logic [31:0]           OUT_MC_sramAddr;
    logic [31:0]           OUT_MC_extAddr;
    logic [31:0]           OUT_MC_extWBAddr;
    logic [15:0]           OUT_MC_size;
    logic                  IN_MC_busy;
    logic                  OUT_busy;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    mem_ctrl_arbiter #(
        .NUM_REQ      (NUM_REQ),
        .ISSUE_TIMEOUT(ISSUE_TIMEOUT)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .IN_req          (IN_req),
        .IN_writeBack    (IN_writeBack),
        .IN_sramAddr     (IN_sramAddr),
        .IN_extAddr      (IN_extAddr),
        .IN_extWBAddr    (IN_extWBAddr),
        .IN_size         (IN_size),
        .OUT_ack         (OUT_ack),
        .OUT_done        (OUT_done),
        .OUT_MC_startRead(OUT_MC_startRead),
        .OUT_MC_writeBack(OUT_MC_writeBack),
        .OUT_MC_sramAddr (OUT_MC_sramAddr),
        .OUT_MC_extAddr  (OUT_MC_extAddr),
        .OUT_MC_extWBAddr(OUT_MC_extWBAddr),
        .OUT_MC_size     (OUT_MC_size),
        .IN_MC_busy      (IN_MC_busy),
        .OUT_busy        (OUT_busy)
    );

    // Outputs are sampled and inputs driven 1 ns after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        IN_req       = '0;
        IN_writeBack = '0;
        IN_sramAddr  = '0;
        IN_extAddr   = '0;
        IN_extWBAddr = '0;
        IN_size      = '0;
        IN_MC_busy   = 1'b0;
    endtask

    task automatic set_cmd(input int i, input logic wb, input logic [31:0] sram,
                           input logic [31:0] ext, input logic [31:0] ext_wb,
                           input logic [15:0] size);
        IN_writeBack[i]        = wb;
        IN_sramAddr[i*32 +: 32]  = sram;
        IN_extAddr[i*32 +: 32]   = ext;
        IN_extWBAddr[i*32 +: 32] = ext_wb;
        IN_size[i*16 +: 16]      = size;
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        clear_inputs();
        tick();
        rst = 1'b1;
    endtask

    task automatic wait_ack(input int max_cycles, output int waited);
        waited = 0;
        do begin
            tick();
            waited++;
        end while (OUT_ack == '0 && waited < max_cycles);
    endtask

    // Memory-controller model, entered in a startRead cycle: busy for `hold` cycles from
    // the next cycle, then done[g] is expected one cycle after busy falls.
    task automatic mc_serve(input int hold, input int g, input logic exp_wb,
                            input logic [31:0] exp_sram, input logic [31:0] exp_ext_wb,
                            input string name);
        int         bad;
        logic [1:0] exp_done;
        bad      = 0;
        exp_done = 2'b01 << g;
        tick();
        IN_MC_busy = 1'b1;
        if (OUT_ack !== 2'b00 || OUT_done !== 2'b00 || OUT_MC_startRead !== 1'b0) bad++;
        for (int c = 0; c < hold; c++) begin
            tick();
            if (c == hold - 1) IN_MC_busy = 1'b0;
            if (OUT_ack !== 2'b00 || OUT_done !== 2'b00 || OUT_MC_startRead !== 1'b0 ||
                OUT_busy !== 1'b1) bad++;
            if (OUT_MC_writeBack !== exp_wb || OUT_MC_sramAddr !== exp_sram ||
                OUT_MC_extWBAddr !== exp_ext_wb) bad++;
        end
        total++;
        if (bad !== 0) $display("FAIL %s_in_flight: %0d bad cycles, expected 0", name, bad);
        else passed++;
        tick();
        total++;
        if (OUT_done !== exp_done || OUT_ack !== 2'b00)
            $display("FAIL %s_done: done=%b ack=%b, expected done=%b ack=00",
                     name, OUT_done, OUT_ack, exp_done);
        else passed++;
        total++;
        if (OUT_MC_writeBack !== exp_wb || OUT_MC_sramAddr !== exp_sram ||
            OUT_MC_extWBAddr !== exp_ext_wb || OUT_busy !== 1'b0)
            $display("FAIL %s_done_cmd: wb=%b sram=%h extwb=%h busy=%b, expected %b %h %h 0",
                     name, OUT_MC_writeBack, OUT_MC_sramAddr, OUT_MC_extWBAddr, OUT_busy,
                     exp_wb, exp_sram, exp_ext_wb);
        else passed++;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        clear_inputs();
        IN_req = 2'b11;
        tick();
        tick();
        total++;
        if (OUT_ack !== 2'b00 || OUT_done !== 2'b00)
            $display("FAIL reset_pulses: ack=%b done=%b, expected 00 00", OUT_ack, OUT_done);
        else passed++;
        total++;
        if ({OUT_MC_startRead, OUT_MC_writeBack, OUT_busy} !== 3'b000)
            $display("FAIL reset_flags: start=%b wb=%b busy=%b, expected 0 0 0",
                     OUT_MC_startRead, OUT_MC_writeBack, OUT_busy);
        else passed++;
        total++;
        if (OUT_MC_sramAddr !== 32'h0 || OUT_MC_extAddr !== 32'h0 ||
            OUT_MC_extWBAddr !== 32'h0 || OUT_MC_size !== 16'h0)
            $display("FAIL reset_cmd: sram=%h ext=%h extwb=%h size=%h, expected all 0",
                     OUT_MC_sramAddr, OUT_MC_extAddr, OUT_MC_extWBAddr, OUT_MC_size);
        else passed++;
        rst    = 1'b1;
        IN_req = 2'b00;
        tick();
        total++;
        if (OUT_busy !== 1'b0 || OUT_ack !== 2'b00)
            $display("FAIL reset_release: busy=%b ack=%b, expected 0 00", OUT_busy, OUT_ack);
        else passed++;
    endtask

    task automatic test_single();
        apply_reset();
        set_cmd(0, 1'b0, 32'h40, 32'h1000, 32'h0, 16'd64);
        IN_req = 2'b01;
        tick();
        total++;
        if (OUT_ack !== 2'b01 || OUT_MC_startRead !== 1'b1 || OUT_busy !== 1'b1)
            $display("FAIL single_ack: ack=%b start=%b busy=%b, expected 01 1 1",
                     OUT_ack, OUT_MC_startRead, OUT_busy);
        else passed++;
        total++;
        if (OUT_MC_sramAddr !== 32'h40 || OUT_MC_extAddr !== 32'h1000 || OUT_MC_size !== 16'd64)
            $display("FAIL single_cmd: sram=%h ext=%h size=%0d, expected 40 1000 64",
                     OUT_MC_sramAddr, OUT_MC_extAddr, OUT_MC_size);
        else passed++;
        IN_req = 2'b00;
        mc_serve(5, 0, 1'b0, 32'h40, 32'h0, "single");
        tick();
        total++;
        if (OUT_done !== 2'b00 || OUT_ack !== 2'b00)
            $display("FAIL single_after: done=%b ack=%b, expected 00 00", OUT_done, OUT_ack);
        else passed++;
    endtask

    task automatic test_contention();
        int g;
        int waited;
        apply_reset();
        set_cmd(0, 1'b0, 32'h100, 32'h1100, 32'h0, 16'd8);
        set_cmd(1, 1'b0, 32'h200, 32'h2200, 32'h0, 16'd16);
        IN_req = 2'b11;
        for (int k = 0; k < 4; k++) begin
            g = k % 2;
            wait_ack(20, waited);
            total++;
            if (OUT_ack !== (2'b01 << g) || OUT_MC_startRead !== 1'b1)
                $display("FAIL contention_grant%0d: ack=%b start=%b, expected %b 1",
                         k, OUT_ack, OUT_MC_startRead, 2'b01 << g);
            else passed++;
            total++;
            if (waited !== 1)
                $display("FAIL contention_latency%0d: ack after %0d cycles, expected 1", k, waited);
            else passed++;
            if (k == 3) IN_req = 2'b00;
            mc_serve(4, g, 1'b0, (g == 0) ? 32'h100 : 32'h200, 32'h0, "contention");
        end
    endtask

    task automatic test_busy_idle();
        int bad;
        bad = 0;
        set_cmd(1, 1'b0, 32'h300, 32'h3300, 32'h0, 16'd4);
        IN_MC_busy = 1'b1;
        IN_req     = 2'b10;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (OUT_ack !== 2'b00 || OUT_busy !== 1'b0) bad++;
        end
        total++;
        if (bad !== 0) $display("FAIL busy_idle_hold: %0d cycles granted while busy, expected 0", bad);
        else passed++;
        IN_MC_busy = 1'b0;
        tick();
        total++;
        if (OUT_ack !== 2'b10 || OUT_MC_sramAddr !== 32'h300)
            $display("FAIL busy_idle_ack: ack=%b sram=%h, expected 10 300", OUT_ack, OUT_MC_sramAddr);
        else passed++;
        IN_req = 2'b00;
        mc_serve(3, 1, 1'b0, 32'h300, 32'h0, "busy_idle");
    endtask

    task automatic test_lost_cmd();
        int bad;
        int acks;
        bad  = 0;
        acks = 0;
        set_cmd(0, 1'b0, 32'h80, 32'h8000, 32'h0, 16'd128);
        IN_req = 2'b01;
        tick();
        total++;
        if (OUT_ack !== 2'b01 || OUT_MC_startRead !== 1'b1)
            $display("FAIL lost_first_issue: ack=%b start=%b, expected 01 1", OUT_ack, OUT_MC_startRead);
        else passed++;
        IN_req = 2'b00;
        for (int k = 1; k <= ISSUE_TIMEOUT; k++) begin
            tick();
            if (OUT_MC_startRead !== 1'b0 || OUT_busy !== 1'b1) bad++;
            if (OUT_ack !== 2'b00) acks++;
        end
        total++;
        if (bad !== 0) $display("FAIL lost_wait: %0d bad cycles before re-issue, expected 0", bad);
        else passed++;
        tick();
        total++;
        if (OUT_MC_startRead !== 1'b1 || OUT_ack !== 2'b00 || acks !== 0)
            $display("FAIL lost_reissue: start=%b ack=%b extra_acks=%0d, expected 1 00 0",
                     OUT_MC_startRead, OUT_ack, acks);
        else passed++;
        total++;
        if (OUT_MC_sramAddr !== 32'h80 || OUT_MC_extAddr !== 32'h8000 || OUT_MC_size !== 16'd128)
            $display("FAIL lost_cmd: sram=%h ext=%h size=%0d, expected 80 8000 128",
                     OUT_MC_sramAddr, OUT_MC_extAddr, OUT_MC_size);
        else passed++;
        mc_serve(2, 0, 1'b0, 32'h80, 32'h0, "lost");
        tick();
        total++;
        if (OUT_done !== 2'b00 || OUT_ack !== 2'b00)
            $display("FAIL lost_single_done: done=%b ack=%b, expected 00 00", OUT_done, OUT_ack);
        else passed++;
    endtask

    task automatic test_writeback();
        set_cmd(0, 1'b0, 32'h12345678, 32'h9000, 32'hcafe0000, 16'd1);
        set_cmd(1, 1'b1, 32'h400, 32'h4000, 32'hdead0000, 16'd32);
        IN_req = 2'b10;
        tick();
        total++;
        if (OUT_ack !== 2'b10 || OUT_MC_writeBack !== 1'b1 || OUT_MC_extWBAddr !== 32'hdead0000)
            $display("FAIL writeback_ack: ack=%b wb=%b extwb=%h, expected 10 1 dead0000",
                     OUT_ack, OUT_MC_writeBack, OUT_MC_extWBAddr);
        else passed++;
        total++;
        if (OUT_MC_sramAddr !== 32'h400 || OUT_MC_extAddr !== 32'h4000 || OUT_MC_size !== 16'd32)
            $display("FAIL writeback_cmd: sram=%h ext=%h size=%0d, expected 400 4000 32",
                     OUT_MC_sramAddr, OUT_MC_extAddr, OUT_MC_size);
        else passed++;
        IN_req       = 2'b00;
        IN_writeBack = 2'b00;
        IN_extWBAddr = '0;
        IN_sramAddr  = '0;
        mc_serve(3, 1, 1'b1, 32'h400, 32'hdead0000, "writeback");
    endtask

    task automatic test_reset_midop();
        set_cmd(0, 1'b0, 32'h500, 32'h5000, 32'h0, 16'd2);
        set_cmd(1, 1'b0, 32'h600, 32'h6000, 32'h0, 16'd3);
        IN_req = 2'b01;
        tick();
        total++;
        if (OUT_ack !== 2'b01)
            $display("FAIL midop_ack: ack=%b, expected 01", OUT_ack);
        else passed++;
        IN_req = 2'b00;
        tick();
        IN_MC_busy = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        total++;
        if (OUT_ack !== 2'b00 || OUT_done !== 2'b00 || OUT_MC_startRead !== 1'b0 ||
            OUT_MC_writeBack !== 1'b0 || OUT_busy !== 1'b0)
            $display("FAIL midop_reset_flags: ack=%b done=%b start=%b wb=%b busy=%b, expected all 0",
                     OUT_ack, OUT_done, OUT_MC_startRead, OUT_MC_writeBack, OUT_busy);
        else passed++;
        total++;
        if (OUT_MC_sramAddr !== 32'h0 || OUT_MC_extAddr !== 32'h0 || OUT_MC_size !== 16'h0)
            $display("FAIL midop_reset_cmd: sram=%h ext=%h size=%h, expected 0 0 0",
                     OUT_MC_sramAddr, OUT_MC_extAddr, OUT_MC_size);
        else passed++;
        rst        = 1'b1;
        IN_MC_busy = 1'b0;
        tick();
        total++;
        if (OUT_done !== 2'b00 || OUT_busy !== 1'b0 || OUT_ack !== 2'b00)
            $display("FAIL midop_no_done: done=%b busy=%b ack=%b, expected 00 0 00",
                     OUT_done, OUT_busy, OUT_ack);
        else passed++;
        IN_req = 2'b11;
        tick();
        total++;
        if (OUT_ack !== 2'b01 || OUT_MC_sramAddr !== 32'h500)
            $display("FAIL midop_rr_restart: ack=%b sram=%h, expected 01 500", OUT_ack, OUT_MC_sramAddr);
        else passed++;
        IN_req = 2'b00;
        mc_serve(2, 0, 1'b0, 32'h500, 32'h0, "midop");
    endtask

    initial begin
        rst = 1'b0;
        clear_inputs();
        test_reset();
        test_single();
        test_contention();
        test_busy_idle();
        test_lost_cmd();
        test_writeback();
        test_reset_midop();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached with %0d/%0d checks passed", passed, total);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mem_ctrl_arbiter.md
Name: mem_ctrl_arbiter

Overview:
- Shares the single memory-controller command port (startRead/writeBack/sramAddr/extAddr/extWBAddr/size, busy) between NUM_REQ requesters, e.g. data-cache fill/writeback and instruction-cache fill.
- Round-robin grant, one transaction in flight, per-requester accept (ack) and completion (done) pulses.
- Re-issues a command the controller never picked up.

Parameters:
- NUM_REQ, 2, number of requesters; index 0 wins the first arbitration after reset.
- ISSUE_TIMEOUT, 8, cycles in WAIT_BUSY without IN_MC_busy rising before startRead is re-pulsed.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-low (rst=0 resets on posedge clk).
- IN_req  in  NUM_REQ  request; held high until OUT_ack for that index.
- IN_writeBack  in  NUM_REQ  per-requester writeBack flag.
- IN_sramAddr  in  NUM_REQ*32  per-requester SRAM address, slice i at [i*32+:32].
- IN_extAddr  in  NUM_REQ*32  per-requester external read address.
- IN_extWBAddr  in  NUM_REQ*32  per-requester external writeback address.
- IN_size  in  NUM_REQ*16  per-requester transfer size, slice i at [i*16+:16].
- OUT_ack  out  NUM_REQ  one-cycle pulse: command captured.
- OUT_done  out  NUM_REQ  one-cycle pulse: transaction finished.
- OUT_MC_startRead  out  1  command strobe.
- OUT_MC_writeBack  out  1  to memory controller.
- OUT_MC_sramAddr  out  32  to memory controller.
- OUT_MC_extAddr  out  32  to memory controller.
- OUT_MC_extWBAddr  out  32  to memory controller.
- OUT_MC_size  out  16  to memory controller.
- IN_MC_busy  in  1  memory controller busy.
- OUT_busy  out  1  arbiter not in IDLE.

Behaviour:
- All outputs are registered.
- Reset (rst=0): state=IDLE; rrPtr=0; grant=0; timeout counter=0; OUT_ack=0, OUT_done=0, OUT_MC_startRead=0, OUT_MC_writeBack=0, OUT_busy=0; OUT_MC_sramAddr, OUT_MC_extAddr, OUT_MC_extWBAddr, OUT_MC_size all =0.
- Reset mid-transaction drops it silently: no done pulse. The memory controller is reset alongside.
- States: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
- IDLE, when any IN_req=1 and IN_MC_busy=0:
  - g = first set req scanning rrPtr, rrPtr+1, …, wrapping modulo NUM_REQ.
  - Latch slice g of every IN_* command field into the OUT_MC_* registers; set OUT_ack[g]=1 and OUT_MC_startRead=1 for the next cycle.
  - grant<=g; rrPtr<=(g+1) mod NUM_REQ; state<=ISSUE.
- IDLE with IN_MC_busy=1: no grant (controller owned elsewhere / still draining).
- ISSUE, exactly 1 cycle: startRead is high this cycle; state<=WAIT_BUSY; counter<=0.
- In ISSUE, clear OUT_ack and OUT_MC_startRead next cycle. Requester g drops IN_req on seeing OUT_ack.
- WAIT_BUSY:
  - IN_MC_busy=1 -> state<=WAIT_DONE.
  - Else counter++; at counter==ISSUE_TIMEOUT-1, re-pulse OUT_MC_startRead for one cycle via state<=ISSUE (command registers unchanged, no second ack).
- WAIT_DONE:
  - IN_MC_busy=0 -> OUT_done[grant]=1 for one cycle; state<=IDLE.
  - The done cycle is also the first IDLE cycle, so arbitration may run in it: the earliest next ack is one cycle after done (back-to-back).
- OUT_busy = (state != IDLE).
- Request latency: req high at cycle t in IDLE with busy low gives ack and startRead high at t+1.
- Fairness: a continuously asserted request is granted within NUM_REQ transactions.
- Requests arriving while not IDLE wait; IN_req deasserted before ack is simply not granted.
- OUT_MC_* command fields stay stable from ISSUE until the next grant.
- Counter width is clog2(ISSUE_TIMEOUT)+1; no wrap issues since it is cleared on every ISSUE.
- Exactly one bit of OUT_ack/OUT_done is ever set; never both ack and done in the same cycle for the same index.

Test Plan:
- Single request: req[0]=1, sram=0x40, ext=0x1000, size=64; MC raises busy 1 cycle after startRead and holds it 5 cycles -> ack[0] and startRead at t+1, done[0] 1 cycle after busy falls, MC outputs match slice 0.
- Contention: req=2'b11 continuously, MC completes each in 4 cycles -> grants alternate 0,1,0,1; rrPtr wraps; ack never coincides with another in-flight transaction.
- Busy at idle: IN_MC_busy=1 held 10 cycles with req[1]=1 -> no ack until the cycle after busy falls, then ack[1].
- Lost command: MC ignores the first startRead, asserts busy after the second -> startRead re-pulsed exactly ISSUE_TIMEOUT cycles after WAIT_BUSY entry; single ack[0], single done[0].
- Reset mid-op: rst=0 during WAIT_DONE -> next cycle all outputs 0, state IDLE, no done; after release, req[1] is granted before req[0] only if rrPtr... (rrPtr=0, so req=2'b11 grants 0 first).
- Writeback field: req[1] with writeBack=1, extWBAddr=0xdead0000 -> OUT_MC_writeBack=1 and OUT_MC_extWBAddr=0xdead0000 from the ack cycle through done.
